pc_mod: RTL and testbench
=========================

# pc_mod

Program-counter block for the ReTReO core. Holds the 6-bit instruction address and advances it once per clock. It can take a PC-relative branch based on the comparison flags, or hold while a flag-producing instruction is still in flight. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- No parameters. Widths are fixed: PC 6 bits, dest 7 bits, branch/compare fields 3 bits.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `branch_loc`  in  6  signed two's-complement PC-relative branch offset (−32..+31)
- `stall_override`  in  1  1 = ignore the flag hazard and advance anyway
- `dest`  in  7  destination descriptor of the instruction in flight
  - `dest[5]` = 1: instruction writes the comparison flags
  - `dest[6]` and `dest[4:0]` are ignored
- `branch_args`  in  3  branch control
  - `[2]` = branch instruction present
  - `[1:0]` = condition select
- `comp`  in  3  comparison flags: `[2]` greater, `[1]` equal, `[0]` less
- `out`  out  6  current PC (registered)

## Operation
- `stall = dest[5] & ~stall_override`.
- Condition selected by `branch_args[1:0]`:
  - 00 → `comp[1]` (equal)
  - 01 → `comp[0]` (less)
  - 10 → `comp[2]` (greater)
  - 11 → 1 (unconditional)
- `take = branch_args[2] & cond`.
- Next-PC priority, evaluated at each rising edge:
  1. stall → `out` holds its value. A branch is not evaluated while stalled; it is evaluated on the first non-stalled edge, using the inputs present at that edge.
  2. take → `out <= out + sign_extend(branch_loc)`, modulo 64.
  3. otherwise → `out <= out + 1`, modulo 64.
- All arithmetic is 6-bit with wrap-around: 63+1 → 0; 0 + (−2) → 62; 1 + (−2) → 63.
- `comp` is consumed combinationally. The block keeps no flag state.
- Inputs are level-sensitive, with no handshake. Any X on an input that the selected path uses propagates into `out`. Don't-care fields (`dest[6]`, `dest[4:0]`, and `branch_loc` when no branch is taken) must not affect `out`.

## Timing
- Reset: `rst_n` low forces `out = 0` immediately, independent of `clk`.
- While `rst_n` is low, `out` stays 0.
- The first edge after `rst_n` rises performs a normal update, so `out` becomes 1 if there is no stall or branch.
- Reset asserted mid-branch or mid-stall: `out` returns to 0 at once, and nothing pending is remembered.
- Latency: an input change affects `out` at the next rising edge, one cycle later. `out` never changes between edges except on reset.
- Stall plus branch in the same cycle: the stall wins, and `out` is unchanged.
- Stall with override in the same cycle: the override wins, and `out` advances or branches normally.
- No combinational path from any input to `out`.

## Test plan
- Reset then free-run: `rst_n` 0→1 with `dest=0`, `branch_args=0` → `out` reads 1, 2, 3 on successive edges; 63 → 0 on wrap.
- Flag hazard: `dest=7'b0100001`, `stall_override=0` → `out` frozen for 3 edges; `dest[6]` / `dest[4:0]` toggling alone has no effect.
- Override: same `dest`, `stall_override=1` → `out` increments by 1 per edge.
- Taken branch: `stall_override=1`, `dest=7'b0100000`, `branch_args=3'b100`, `comp=3'b010`, `branch_loc=−2` → `out` decreases by 2 per edge (e.g. 5 → 3 → 1 → 63).
- Not-taken branch: `branch_args=3'b110`, `comp=3'b010` → `out` increments by 1. Then `dest=0`, `stall_override=0` → still increments.
- Remaining conditions and reset:
  - `branch_args=3'b101` with `comp=3'b001` → taken.
  - `branch_args=3'b111` with `comp=0` → taken.
  - `rst_n` pulsed low between edges → `out` is 0 immediately.

Source files
------------

// File: rtl/pc_mod.sv
// Program counter for the ReTReO fetch stage: advances by one each clock,
// takes flag-conditioned PC-relative branches, and holds while flags are pending.
module pc_mod (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] branch_loc,
  input  logic       stall_override,
  input  logic [6:0] dest,
  input  logic [2:0] branch_args,
  input  logic [2:0] comp,
  output logic [5:0] out
);

  logic       stall;
  logic       cond;
  logic       take;
  logic [5:0] next_pc;

  // Only dest[5] (flag writer) matters; the rest of the descriptor is not ours.
  logic unused_dest;
  assign unused_dest = ^{dest[6], dest[4:0]};

  assign stall = dest[5] & ~stall_override;

  always_comb begin
    cond = 1'b0;
    case (branch_args[1:0])
      2'b00:   cond = comp[1];
      2'b01:   cond = comp[0];
      2'b10:   cond = comp[2];
      default: cond = 1'b1;
    endcase
  end

  assign take = branch_args[2] & cond;

  // A 6-bit add of the offset is the same as adding its sign extension mod 64.
  always_comb begin
    next_pc = out + 6'd1;
    if (stall)
      next_pc = out;
    else if (take)
      next_pc = out + branch_loc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out <= 6'd0;
    else
      out <= next_pc;
  end

endmodule

// File: tb/tb_pc_mod.sv
// Directed bench for pc_mod: free-run, wrap, flag hazard, override, branch
// conditions and asynchronous reset, with hand-computed PC values.
module tb_pc_mod;

  logic       clk;
  logic       rst_n;
  logic [5:0] branch_loc;
  logic       stall_override;
  logic [6:0] dest;
  logic [2:0] branch_args;
  logic [2:0] comp;
  logic [5:0] pc_out;

  int checks;
  int errors;

  pc_mod dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_loc     (branch_loc),
    .stall_override (stall_override),
    .dest           (dest),
    .branch_args    (branch_args),
    .comp           (comp),
    .out            (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] exp);
    @(posedge clk);
    #1;
    chk(tag, pc_out, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    branch_loc = 6'd0;
    stall_override = 1'b0;
    dest = 7'd0;
    branch_args = 3'd0;
    comp = 3'd0;

    #3 chk("reset_async", pc_out, 6'd0);
    step("reset_held", 6'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("run_1", 6'd1);
    step("run_2", 6'd2);
    step("run_3", 6'd3);

    // 3 + (-4) -> 63 via unconditional branch, then wrap to 0
    branch_args = 3'b111; branch_loc = 6'b111100;
    step("uncond_to_63", 6'd63);
    branch_args = 3'b000;
    step("wrap_63_0", 6'd0);

    dest = 7'b0100001;
    step("stall_1", 6'd0);
    step("stall_2", 6'd0);
    step("stall_3", 6'd0);
    dest = 7'b1111111;
    step("stall_dc_bits", 6'd0);
    branch_args = 3'b111; branch_loc = 6'd10;
    step("stall_beats_branch", 6'd0);
    // branch seen on the first unstalled edge
    dest = 7'd0;
    step("branch_after_stall", 6'd10);
    branch_args = 3'b000;

    dest = 7'b0100001; stall_override = 1'b1;
    step("override_1", 6'd11);
    step("override_2", 6'd12);
    step("override_3", 6'd13);
    dest = 7'b1011111; stall_override = 1'b0;
    step("dc_bits_1", 6'd14);
    dest = 7'b1000000;
    step("dc_bits_2", 6'd15);

    stall_override = 1'b1; dest = 7'b0100000;
    branch_args = 3'b111; branch_loc = 6'b110110;
    step("uncond_minus10", 6'd5);
    branch_args = 3'b100; comp = 3'b010; branch_loc = 6'b111110;
    step("eq_taken_1", 6'd3);
    step("eq_taken_2", 6'd1);
    step("eq_taken_3", 6'd63);

    branch_args = 3'b110; comp = 3'b010; branch_loc = 6'b010101;
    step("gt_not_taken_1", 6'd0);
    step("gt_not_taken_2", 6'd1);
    dest = 7'd0; stall_override = 1'b0;
    step("gt_not_taken_3", 6'd2);

    branch_args = 3'b101; comp = 3'b001; branch_loc = 6'd5;
    step("lt_taken", 6'd7);
    comp = 3'b010;
    step("lt_not_taken", 6'd8);
    branch_args = 3'b110; comp = 3'b100; branch_loc = 6'd3;
    step("gt_taken", 6'd11);
    branch_args = 3'b100; comp = 3'b101;
    step("eq_not_taken", 6'd12);
    branch_args = 3'b011; comp = 3'b111;
    step("no_branch_bit", 6'd13);
    branch_args = 3'b111; comp = 3'b000; branch_loc = 6'b110011;
    step("uncond_minus13", 6'd0);
    branch_loc = 6'b111110;
    step("zero_minus2", 6'd62);
    branch_loc = 6'd1;
    step("plus1_to_63", 6'd63);
    branch_loc = 6'b100000;
    step("minus32", 6'd31);
    branch_loc = 6'b011111;
    step("plus31", 6'd62);
    branch_args = 3'b000;
    step("free_63", 6'd63);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_mid_cycle", pc_out, 6'd0);
    dest = 7'b0100000; branch_args = 3'b111; branch_loc = 6'd9;
    step("reset_low_edge", 6'd0);
    @(negedge clk);
    rst_n = 1'b1; dest = 7'd0; branch_args = 3'b000;
    step("after_reset", 6'd1);
    step("after_reset_2", 6'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
